// File: rtl/rename_pkg.sv
// Shared rename types: default register-file sizes, phys tag / free-list pointer
// types and the free-list state encoding.
package rename_pkg;

  localparam int ARCHFILE_SIZE_DEF = 32;
  localparam int PHYSFILE_SIZE_DEF = 256;
  localparam int PTAG_W            = $clog2(PHYSFILE_SIZE_DEF);

  typedef logic [PTAG_W-1:0] ptag_t;
  typedef logic [PTAG_W:0]   fl_ptr_t;

  typedef enum logic {
    FL_INIT,
    FL_RUN
  } fl_state_t;

endpackage

// File: rtl/phys_freelist_if.sv
// Rename/ROB-facing handshake bundle of the physical free list.
// master = rename/ROB side, slave = free list.
interface phys_freelist_if
  import rename_pkg::*;
#(
  parameter int PHYSFILE_SIZE = PHYSFILE_SIZE_DEF
);
  localparam int TW = $clog2(PHYSFILE_SIZE);

  logic          alloc_req;
  logic          alloc_valid;
  logic [TW-1:0] alloc_phys;
  logic          commit_alloc;
  logic          free_valid;
  logic [TW-1:0] free_phys;
  logic          rollback;
  logic [TW:0]   free_count;
  logic          init_done;

  modport master (
    output alloc_req, commit_alloc, free_valid, free_phys, rollback,
    input  alloc_valid, alloc_phys, free_count, init_done
  );

  modport slave (
    input  alloc_req, commit_alloc, free_valid, free_phys, rollback,
    output alloc_valid, alloc_phys, free_count, init_done
  );

endinterface

// File: rtl/freelist_ram.sv
// Free-list storage: one synchronous write port, one asynchronous read port.
module freelist_ram
  import rename_pkg::*;
#(
  parameter int DEPTH = PHYSFILE_SIZE_DEF,
  parameter int WIDTH = PTAG_W
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/phys_freelist.sv
// Circular free list of physical tags with speculative head, committed head and tail.
// Optional same-cycle free->alloc bypass on an empty list: PHYS_FREELIST_BYPASS_EN.
module phys_freelist
  import rename_pkg::*;
#(
  parameter int ARCHFILE_SIZE = ARCHFILE_SIZE_DEF,
  parameter int PHYSFILE_SIZE = PHYSFILE_SIZE_DEF
) (
  input logic             clk,
  input logic             rst,
  phys_freelist_if.slave  fl
);

  localparam int TW     = $clog2(PHYSFILE_SIZE);
  localparam int INIT_N = PHYSFILE_SIZE - ARCHFILE_SIZE;

  fl_state_t     state;
  logic [TW:0]   head;
  logic [TW:0]   commit_head;
  logic [TW:0]   tail;
  logic          init_done_q;

  logic [TW:0]   count_raw;
  logic [TW:0]   commit_nxt;
  logic          run;
  logic          bypass;
  logic          valid;
  logic          alloc_fire;
  logic          commit_ok;
  logic          we;
  logic [TW-1:0] wdata;
  logic [TW-1:0] rdata;

  freelist_ram #(
    .DEPTH (PHYSFILE_SIZE),
    .WIDTH (TW)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (tail[TW-1:0]),
    .wdata (wdata),
    .raddr (head[TW-1:0]),
    .rdata (rdata)
  );

  always_comb begin
    count_raw = tail - head;
    run       = (state == FL_RUN) && !rst;
    bypass    = 1'b0;
`ifdef PHYS_FREELIST_BYPASS_EN
    bypass    = run && (count_raw == '0) && fl.free_valid && !fl.rollback;
`endif
    valid      = run && !fl.rollback && ((count_raw != '0) || bypass);
    alloc_fire = fl.alloc_req && valid;
    // commit_head may never pass head; an illegal commit is simply dropped
    commit_ok  = run && fl.commit_alloc && (commit_head != head);
    commit_nxt = commit_head + {{TW{1'b0}}, commit_ok};

    we    = 1'b0;
    wdata = fl.free_phys;
    if (!rst) begin
      if (state == FL_INIT) begin
        we    = 1'b1;
        wdata = TW'(ARCHFILE_SIZE) + tail[TW-1:0];
      end else begin
        we    = fl.free_valid;
      end
    end
  end

  assign fl.alloc_valid = valid;
  assign fl.alloc_phys  = bypass ? fl.free_phys : rdata;
  assign fl.free_count  = rst ? '0 : count_raw;
  assign fl.init_done   = init_done_q && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FL_INIT;
      head        <= '0;
      commit_head <= '0;
      tail        <= '0;
      init_done_q <= 1'b0;
    end else begin
      unique case (state)
        FL_INIT: begin
          tail <= tail + 1'b1;
          if (tail == (TW+1)'(INIT_N - 1)) begin
            state       <= FL_RUN;
            init_done_q <= 1'b1;
          end
        end
        FL_RUN: begin
          if (fl.free_valid) tail <= tail + 1'b1;
          commit_head <= commit_nxt;
          // rollback lands on the committed head, including this cycle's commit
          if (fl.rollback) head <= commit_nxt;
          else             head <= head + {{TW{1'b0}}, alloc_fire};
        end
        default: state <= FL_INIT;
      endcase
    end
  end

endmodule

// File: doc/phys_freelist.md
Name: phys_freelist

Overview:
- Circular free list of physical register tags.
- Sits directly upstream of the architectural register file. It supplies the new physical tag for each renamed destination (arch_wr_phys).
- It reclaims old physical tags (arch_wr_oldphys) when the ROB commits.
- Tracks a speculative head and a committed head, so rollback restores all speculatively allocated tags in one cycle.

Parameters:
- ARCHFILE_SIZE, 32, number of architectural registers; phys tags 0..ARCHFILE_SIZE-1 are mapped at reset and never start on the list.
- PHYSFILE_SIZE, 256, number of physical registers; power of two; storage depth of the list.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- alloc_req  in  1  rename consumes the presented tag this cycle
- alloc_valid  out  1  a free tag is presented on alloc_phys
- alloc_phys  out  $clog2(PHYSFILE_SIZE)  tag at speculative head
- commit_alloc  in  1  ROB retires one destination-writing uop; its allocation becomes non-speculative
- free_valid  in  1  push a reclaimed tag
- free_phys  in  $clog2(PHYSFILE_SIZE)  tag to reclaim (old phys of the retiring uop)
- rollback  in  1  discard all speculative allocations
- free_count  out  $clog2(PHYSFILE_SIZE)+1  tags between speculative head and tail
- init_done  out  1  initialisation complete

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Pointers: head, commit_head and tail are each $clog2(PHYSFILE_SIZE)+1 bits; the MSB is the wrap bit. free_count = tail - head (modulo arithmetic).
- States: INIT and RUN.
- Reset:
  - rst forces INIT: head=0, commit_head=0, tail=0, init index=0.
  - Outputs during reset: alloc_valid=0, init_done=0, free_count=0.
  - rst asserted mid-operation discards all contents and restarts INIT.
- INIT:
  - One entry is written per cycle: entry[i] = ARCHFILE_SIZE+i, tail++, for i = 0..PHYSFILE_SIZE-ARCHFILE_SIZE-1.
  - After the last write: state becomes RUN and init_done=1. Total 224 cycles with defaults.
  - alloc_req, free_valid, commit_alloc and rollback are ignored in INIT.
- Allocation:
  - alloc_valid = RUN && (free_count != 0) && !rollback.
  - alloc_phys = entry[head], read combinationally with zero latency.
  - alloc_req && alloc_valid increments head at the clock edge.
  - alloc_req while !alloc_valid is ignored (no underflow).
- Free:
  - free_valid in RUN writes entry[tail] and increments tail next edge.
  - Overflow cannot legally occur (count never exceeds PHYSFILE_SIZE-ARCHFILE_SIZE). The bench flags it as an error.
- Commit:
  - commit_alloc increments commit_head.
  - commit_head == head with commit_alloc asserted is illegal; commit_head is held and the bench flags it.
- Rollback:
  - Next edge: head <= commit_head (including any same-cycle commit increment).
  - A same-cycle alloc is not performed.
  - A same-cycle free is accepted.
- Simultaneous alloc+free with free_count==0: no allocation that cycle; the freed tag is available the following cycle (changed under the optional feature).
- Width and wrap: pointers wrap naturally. The index is the low $clog2(PHYSFILE_SIZE) bits.

Optional Feature:
- Macro: PHYS_FREELIST_BYPASS_EN.
- When defined, with free_count==0 and free_valid in RUN, without rollback:
  - alloc_valid=1 and alloc_phys=free_phys in the same cycle.
  - If alloc_req is asserted, the tag is still written at tail and head and tail both increment, keeping commit_head accounting exact.
- When undefined: no bypass; behaviour as above.

Decomposition:
- Shared package rename_pkg:
  - ARCHFILE_SIZE / PHYSFILE_SIZE defaults.
  - ptag_t (phys tag width).
  - fl_ptr_t (tag width + 1).
  - freelist state enum {FL_INIT, FL_RUN}.
- Sub-module freelist_ram: PHYSFILE_SIZE x tag-width storage, one synchronous write port, one asynchronous read port.
- Pointers and FSM stay in phys_freelist.

Test Plan:
- Reset then idle: init_done rises after exactly 224 cycles in RUN; free_count=224, alloc_valid=1, alloc_phys=32.
- Allocate 3 (tags 32, 33, 34), then rollback: next cycle alloc_phys=32, free_count=224.
- Allocate 2, commit_alloc once, rollback: alloc_phys=33, free_count=223.
- Drain 224 allocs (last tag 255): alloc_valid=0. Free tag 5 on the following cycle: alloc_valid=0 that cycle, then alloc_valid=1 with alloc_phys=5 the next. With PHYS_FREELIST_BYPASS_EN: alloc_phys=5 the same cycle.
- Wrap: 300 alloc/free pairs with commits: tags returned in FIFO order across the pointer wrap; free_count stays 224.
- rst asserted mid-stream after 10 allocs: alloc_valid=0 and init_done=0 the next cycle; after re-init, alloc_phys=32.
